lsu_mem_bridge: RTL and testbench
=================================

Name: lsu_mem_bridge

Overview:
- Load/store bridge between the CPU execute stage and the word-only data memory (`Data_mem`). It feeds that memory and consumes its read data.
- Turns byte, halfword and word loads/stores into word accesses. Sub-word stores use read-modify-write.
- Checks alignment and sign/zero-extends load data.
- Drives a stall request back to the pipeline while an access is in flight.

Parameters:
- READ_LATENCY, 1, cycles from Mem_Address presented to Mem_ReadData valid; legal values 1..3.
- MEM_WORDS_LOG2, 14, log2 of data memory depth in words; used only by the optional bounds check.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req  in  1  access request; held high with all request inputs stable until Done.
- MemRead  in  1  request is a load.
- MemWrite  in  1  request is a store.
- Size  in  2  00 byte, 01 halfword, 10 word; 11 illegal.
- Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- Address  in  32  byte address.
- WriteData  in  32  store data, right-justified.
- ReadData  out  32  extended load result; valid while Done is high, then held.
- Done  out  1  one-cycle completion pulse.
- AddrError  out  1  one-cycle pulse, coincident with Done, on a rejected request.
- Stall  out  1  combinational: Req & ~Done.
- Mem_Write  out  1  write enable to data memory.
- Mem_Address  out  32  word-aligned byte address ({Address[31:2],2'b00}).
- Mem_WriteData  out  32  full word to write.
- Mem_ReadData  in  32  word from data memory.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; latency counter 0.
- Reset is asynchronous. Asserting it mid-operation drops Mem_Write immediately and abandons the access; no Done is issued.
- Memory model: Mem_Write is sampled at the rising edge. Read data is valid READ_LATENCY cycles after the address is registered.
- Request capture:
  - In IDLE with Req=1, Address, Size, Unsigned, WriteData and the operation type are registered.
  - If MemRead and MemWrite are both 1, the request is a store.
  - If neither is 1, Done pulses the next cycle with no memory access and AddrError=0.
- Alignment rules:
  - Size=01 with Address[0]=1 is illegal.
  - Size=10 with Address[1:0]≠0 is illegal.
  - Size=11 is illegal.
  - Illegal request → ERR state for one cycle: Done=1, AddrError=1, no memory access, ReadData unchanged.
- FSM states: IDLE, RD, WR, ERR, DONE.
  - Load: IDLE → RD; count READ_LATENCY cycles; capture Mem_ReadData; → DONE. Done at cycle READ_LATENCY+1 after acceptance.
  - Word store: IDLE → WR. Mem_Write=1 for exactly one cycle with Mem_WriteData=WriteData, then → DONE.
  - Sub-word store: IDLE → RD → WR → DONE.
    - WR writes the fetched word with the addressed lane(s) replaced.
    - Byte lane k = Address[1:0] covers bits [8k+7:8k]; halfword uses lanes Address[1],0 and Address[1],1.
    - Little-endian throughout.
  - DONE: Done=1 for one cycle → IDLE.
  - A new request is not accepted in the DONE cycle; the earliest acceptance is the following IDLE cycle.
- Load extension:
  - Byte: selected lane, extended from bit 7 (or zero-extended when Unsigned=1).
  - Halfword: selected lane pair, extended from bit 15 (or zero-extended when Unsigned=1).
  - Word: passed through; Unsigned is ignored.
- Mem_Address is held from acceptance until DONE. Mem_Write is never high outside WR.
- Request inputs changing after acceptance are ignored; the registered copy is used.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- Defined: an accepted request with any Address bit at or above MEM_WORDS_LOG2+2 set is treated as illegal: ERR path, AddrError=1, no memory access.
- Undefined: upper address bits are passed unchanged to Mem_Address; no range check.

Test Plan:
- Memory word at 0x10 = 0x80FF7F01. Load byte signed @0x13 → ReadData=0xFFFFFF80. Unsigned → 0x00000080. Done exactly READ_LATENCY+1 cycles after Req.
- Word at 0x10 = 0x11223344. Store half 0x0000ABCD @0x12 → one RD then one WR with Mem_WriteData=0xABCD3344. Word readback = 0xABCD3344.
- Store word 0xDEADBEEF @0x20 → single Mem_Write cycle with no RD, Done the next cycle. Load word @0x20 → 0xDEADBEEF.
- Load half @0x11, load word @0x22, Size=11 → each gives Done+AddrError on the same cycle, Mem_Write never asserted, ReadData unchanged.
- Assert Reset_n=0 during the RD of a sub-word store → Mem_Write stays 0, no Done, FSM in IDLE. A memory word previously set to 0x11223344 is unmodified.
- With LSU_BOUNDS_CHECK_EN defined and MEM_WORDS_LOG2=14: load word @0x00010000 → AddrError=1. Load word @0x0000FFFC → normal completion.

Source files
------------

// File: rtl/lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_bridge
// Purpose  : Load/store bridge from the CPU execute stage to a word-only data
//            memory. It turns byte/halfword/word accesses into word accesses,
//            using read-modify-write for sub-word stores. It also checks
//            alignment, sign/zero-extends load data and raises a stall
//            request while an access is in flight.
// Ports    : Clock, Reset_n             - clock, async active-low reset
//            Req, MemRead, MemWrite,
//            Size, Unsigned, Address,
//            WriteData                  - request from pipeline (held until Done)
//            ReadData, Done, AddrError,
//            Stall                      - completion/result back to pipeline
//            Mem_Write, Mem_Address,
//            Mem_WriteData,
//            Mem_ReadData               - word interface to data memory
// Options  : `define LSU_BOUNDS_CHECK_EN rejects addresses beyond the
//            2**MEM_WORDS_LOG2-word memory.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_bridge #(
    parameter int READ_LATENCY   = 1,
    parameter int MEM_WORDS_LOG2 = 14
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Req,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Done,
    output logic        AddrError,
    output logic        Stall,
    output logic        Mem_Write,
    output logic [31:0] Mem_Address,
    output logic [31:0] Mem_WriteData,
    input  logic [31:0] Mem_ReadData
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_ERR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] C_LAT_LAST = 2'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        store_q;
    logic [31:0] wdata_q;
    logic [31:0] rword_q;   // fetched word for read-modify-write
    logic [31:0] rdata_q;   // extended load result

    logic        accept;
    logic        rd_last;
    logic        misalign;
    logic        oob;
    logic        illegal;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    assign accept  = (state_q == S_IDLE) && Req;
    assign rd_last = (state_q == S_RD) && (cnt_q == C_LAT_LAST);

    assign misalign = (Size == 2'b11)
                    | ((Size == 2'b01) & Address[0])
                    | ((Size == 2'b10) & (|Address[1:0]));

`ifdef LSU_BOUNDS_CHECK_EN
    // Any byte-address bit above the implemented word range marks the access bad.
    assign oob = (Address >> (MEM_WORDS_LOG2 + 2)) != 32'd0;
`else
    // Range check disabled; the depth is never negative so this is constant 0.
    assign oob = (MEM_WORDS_LOG2 < 0);
`endif

    assign illegal = misalign | oob;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        Done      = 1'b0;
        AddrError = 1'b0;
        Mem_Write = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 2'd0;
                if (Req) begin
                    // Neither load nor store: complete without touching memory.
                    if (!MemRead && !MemWrite)            state_d = S_DONE;
                    else if (illegal)                     state_d = S_ERR;
                    else if (MemWrite && (Size == 2'b10)) state_d = S_WR;
                    else                                  state_d = S_RD;
                end
            end
            S_RD: begin
                if (cnt_q == C_LAT_LAST) begin
                    cnt_d   = 2'd0;
                    state_d = store_q ? S_WR : S_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_WR: begin
                Mem_Write = 1'b1;
                state_d   = S_DONE;
            end
            S_ERR: begin
                Done      = 1'b1;
                AddrError = 1'b1;
                state_d   = S_IDLE;
            end
            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Request capture and read data capture
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            store_q <= 1'b0;
            wdata_q <= 32'd0;
            rword_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                addr_q  <= Address;
                size_q  <= Size;
                uns_q   <= Unsigned;
                store_q <= MemWrite;   // both set counts as a store
                wdata_q <= WriteData;
            end
            if (rd_last) begin
                if (store_q) rword_q <= Mem_ReadData;
                else         rdata_q <= ld_ext;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Load lane select and extension (little-endian)
    // ------------------------------------------------------------------------
    always_comb begin
        ld_byte = Mem_ReadData[7:0];
        case (addr_q[1:0])
            2'd0:    ld_byte = Mem_ReadData[7:0];
            2'd1:    ld_byte = Mem_ReadData[15:8];
            2'd2:    ld_byte = Mem_ReadData[23:16];
            default: ld_byte = Mem_ReadData[31:24];
        endcase
        ld_half = addr_q[1] ? Mem_ReadData[31:16] : Mem_ReadData[15:0];
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = Mem_ReadData;
        endcase
    end

    // ------------------------------------------------------------------------
    // Store lane merge into the fetched word
    // ------------------------------------------------------------------------
    always_comb begin
        merged = wdata_q;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    merged = {rword_q[31:8], wdata_q[7:0]};
                    2'd1:    merged = {rword_q[31:16], wdata_q[7:0], rword_q[7:0]};
                    2'd2:    merged = {rword_q[31:24], wdata_q[7:0], rword_q[15:0]};
                    default: merged = {wdata_q[7:0], rword_q[23:0]};
                endcase
            end
            2'b01: begin
                merged = addr_q[1] ? {wdata_q[15:0], rword_q[15:0]}
                                   : {rword_q[31:16], wdata_q[15:0]};
            end
            default: merged = wdata_q;
        endcase
    end

    assign ReadData      = rdata_q;
    assign Mem_Address   = {addr_q[31:2], 2'b00};
    assign Mem_WriteData = merged;
    assign Stall         = Req & ~Done;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_bridge
// Purpose  : Directed self-checking bench for lsu_mem_bridge with a small
//            word memory model (read latency 1, write at rising edge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_bridge;

    logic        Clock     = 1'b0;
    logic        Reset_n   = 1'b0;
    logic        Req       = 1'b0;
    logic        MemRead   = 1'b0;
    logic        MemWrite  = 1'b0;
    logic [1:0]  Size      = 2'd0;
    logic        Unsigned  = 1'b0;
    logic [31:0] Address   = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        Done;
    logic        AddrError;
    logic        Stall;
    logic        Mem_Write;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_WriteData;
    logic [31:0] Mem_ReadData;

    int checks   = 0;
    int failures = 0;

    // results of the most recent request
    int          r_lat;
    int          r_wr;
    logic [31:0] r_wd;
    logic [31:0] r_rd;
    logic        r_ae;
    logic        r_stall1;
    logic        r_stall_done;
    logic [31:0] r_ma;

    // memory model with backdoor preload port
    logic [31:0] mem [0:63];
    logic        bd_en  = 1'b0;
    logic [5:0]  bd_idx = 6'd0;
    logic [31:0] bd_val = 32'd0;

    lsu_mem_bridge #(.READ_LATENCY(1), .MEM_WORDS_LOG2(14)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Req          (Req),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Size         (Size),
        .Unsigned     (Unsigned),
        .Address      (Address),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .Done         (Done),
        .AddrError    (AddrError),
        .Stall        (Stall),
        .Mem_Write    (Mem_Write),
        .Mem_Address  (Mem_Address),
        .Mem_WriteData(Mem_WriteData),
        .Mem_ReadData (Mem_ReadData)
    );

    always #5 Clock = ~Clock;

    assign Mem_ReadData = mem[Mem_Address[7:2]];

    always @(posedge Clock) begin
        if (Mem_Write)  mem[Mem_Address[7:2]] <= Mem_WriteData;
        else if (bd_en) mem[bd_idx] <= bd_val;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        bd_en  = 1'b1;
        bd_idx = idx;
        bd_val = val;
        @(posedge Clock); #1;
        bd_en  = 1'b0;
    endtask

    // Issue one request, wait for Done (bounded), record what happened.
    task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr,
                          input logic [31:0] wd, input logic scramble);
        bit got;
        MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns;
        Address = addr; WriteData = wd; Req = 1'b1;
        got = 1'b0; r_lat = 0; r_wr = 0; r_wd = 32'd0;
        for (int i = 1; i <= 20; i++) begin
            if (!got) begin
                @(posedge Clock); #1;
                if (i == 1) begin
                    r_ma     = Mem_Address;
                    r_stall1 = Stall;
                end
                if (scramble && i == 1) begin
                    Address = ~addr; Size = ~sz; Unsigned = ~uns;
                    WriteData = ~wd; MemRead = ~rd; MemWrite = ~wr;
                end
                if (Mem_Write) begin
                    r_wr++;
                    r_wd = Mem_WriteData;
                end
                if (Done) begin
                    got          = 1'b1;
                    r_lat        = i;
                    r_rd         = ReadData;
                    r_ae         = AddrError;
                    r_stall_done = Stall;
                end
            end
        end
        if (!got) chk("timeout_done", 32'd0, 32'd1);
        Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge Clock); #1;
        chk("done_one_cycle", {31'd0, Done}, 32'd0);
        chk("ae_one_cycle", {31'd0, AddrError}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t loads [8];

    initial begin
        loads[0] = '{2'b00, 1'b0, 32'h13, 32'hFFFFFF80};
        loads[1] = '{2'b00, 1'b1, 32'h13, 32'h00000080};
        loads[2] = '{2'b00, 1'b0, 32'h12, 32'hFFFFFFFF};
        loads[3] = '{2'b00, 1'b0, 32'h11, 32'h0000007F};
        loads[4] = '{2'b01, 1'b0, 32'h10, 32'h00007F01};
        loads[5] = '{2'b01, 1'b0, 32'h12, 32'hFFFF80FF};
        loads[6] = '{2'b01, 1'b1, 32'h12, 32'h000080FF};
        loads[7] = '{2'b10, 1'b1, 32'h10, 32'h80FF7F01};

        // ---------------- reset state ----------------
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_readdata", ReadData, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_addrerror", {31'd0, AddrError}, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_mem_write", {31'd0, Mem_Write}, 32'd0);
        chk("rst_mem_address", Mem_Address, 32'd0);
        chk("rst_mem_wdata", Mem_WriteData, 32'd0);
        Reset_n = 1'b1;
        @(posedge Clock); #1;

        // ---------------- loads with extension ----------------
        poke(6'd4, 32'h80FF7F01);
        foreach (loads[k]) begin
            do_req(1'b1, 1'b0, loads[k].sz, loads[k].uns, loads[k].addr, 32'd0, 1'b0);
            chk($sformatf("ld%0d_data", k), r_rd, loads[k].exp);
            chk($sformatf("ld%0d_latency", k), r_lat, 32'd2);
            chk($sformatf("ld%0d_nowrite", k), r_wr, 32'd0);
            chk($sformatf("ld%0d_addrerr", k), {31'd0, r_ae}, 32'd0);
        end
        chk("ld_mem_address", r_ma, 32'h10);
        chk("ld_stall_busy", {31'd0, r_stall1}, 32'd1);
        chk("ld_stall_done", {31'd0, r_stall_done}, 32'd0);

        // ---------------- sub-word stores (read-modify-write) ----------------
        poke(6'd4, 32'h11223344);
        do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000ABCD, 1'b0);
        chk("sh_latency", r_lat, 32'd3);
        chk("sh_writes", r_wr, 32'd1);
        chk("sh_wdata", r_wd, 32'hABCD3344);
        chk("sh_mem", mem[4], 32'hABCD3344);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0);
        chk("sh_readback", r_rd, 32'hABCD3344);
        do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55, 1'b0);
        chk("sb_wdata", r_wd, 32'hABCD5544);
        do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h00000066, 1'b1);
        chk("sb_scr_wdata", r_wd, 32'hABCD5566);
        chk("sb_scr_mem", mem[4], 32'hABCD5566);

        // ---------------- word store / load ----------------
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0);
        chk("sw_latency", r_lat, 32'd2);
        chk("sw_writes", r_wr, 32'd1);
        chk("sw_wdata", r_wd, 32'hDEADBEEF);
        chk("sw_mem_address", r_ma, 32'h20);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 1'b1);
        chk("lw_scr_data", r_rd, 32'hDEADBEEF);
        chk("lw_scr_latency", r_lat, 32'd2);

        // ---------------- illegal requests ----------------
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 1'b0);
        chk("err_lh_ae", {31'd0, r_ae}, 32'd1);
        chk("err_lh_latency", r_lat, 32'd1);
        chk("err_lh_rd", r_rd, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'd0, 1'b0);
        chk("err_lw_ae", {31'd0, r_ae}, 32'd1);
        chk("err_lw_rd", r_rd, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'd0, 1'b0);
        chk("err_sz3_ae", {31'd0, r_ae}, 32'd1);
        chk("err_sz3_latency", r_lat, 32'd1);
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h21, 32'h0, 1'b0);
        chk("err_sw_ae", {31'd0, r_ae}, 32'd1);
        chk("err_sw_writes", r_wr, 32'd0);
        chk("err_sw_mem", mem[8], 32'hDEADBEEF);

        // ---------------- neither load nor store ----------------
        do_req(1'b0, 1'b0, 2'b11, 1'b0, 32'h23, 32'h0, 1'b0);
        chk("nop_latency", r_lat, 32'd1);
        chk("nop_ae", {31'd0, r_ae}, 32'd0);
        chk("nop_writes", r_wr, 32'd0);
        chk("nop_rd", r_rd, 32'hDEADBEEF);

        // ---------------- both set counts as store ----------------
        do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h24, 32'h12345678, 1'b0);
        chk("both_writes", r_wr, 32'd1);
        chk("both_mem", mem[9], 32'h12345678);

        // ---------------- reset during sub-word store RD ----------------
        poke(6'd4, 32'h11223344);
        MemRead = 1'b0; MemWrite = 1'b1; Size = 2'b00; Unsigned = 1'b0;
        Address = 32'h10; WriteData = 32'h99; Req = 1'b1;
        @(posedge Clock); #1;
        chk("rmw_rd_stall", {31'd0, Stall}, 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("arst_mem_write", {31'd0, Mem_Write}, 32'd0);
        chk("arst_done", {31'd0, Done}, 32'd0);
        chk("arst_readdata", ReadData, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge Clock); #1;
            chk($sformatf("arst_hold_mw%0d", c), {31'd0, Mem_Write}, 32'd0);
            chk($sformatf("arst_hold_done%0d", c), {31'd0, Done}, 32'd0);
        end
        Req = 1'b0; MemWrite = 1'b0;
        Reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clock); #1;
            chk($sformatf("post_rst_done%0d", c), {31'd0, Done}, 32'd0);
            chk($sformatf("post_rst_mw%0d", c), {31'd0, Mem_Write}, 32'd0);
        end
        chk("arst_mem_intact", mem[4], 32'h11223344);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0);
        chk("post_rst_ld_latency", r_lat, 32'd2);
        chk("post_rst_ld_data", r_rd, 32'h11223344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
